// File: rtl/pulse_stretch_if.sv
// Tick-to-level stretcher signal bundle: trigger/length in, stretched level and status out.
interface pulse_stretch_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic [WIDTH-1:0] len;
  logic             level;
  logic             busy;
  logic             drop;

  modport master (output tick, len, input level, busy, drop);
  modport slave  (input tick, len, output level, busy, drop);
endinterface

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle tick into a level held for len cycles, followed by a fixed low gap.
// Ticks that cannot be accepted are flagged on drop; RETRIG lets a tick extend a running pulse.
module pulse_stretch #(
  parameter int WIDTH  = 8,
  parameter int GAP    = 2,
  parameter bit RETRIG = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  pulse_stretch_if.slave ps
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW_GAP = 2'd2
  } state_t;

  localparam int           GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, len_load;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             level_r, busy_r, drop_r;
  logic             level_n, busy_n, drop_n;

  // len==0 is treated as a one-cycle pulse
  assign len_load = (ps.len == '0) ? '0 : ps.len - WIDTH'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ps.tick) begin
          state_n = HIGH;
          cnt_n   = len_load;
        end
      end
      HIGH: begin
        if (ps.tick && RETRIG) begin
          cnt_n = len_load;
        end else begin
          drop_n = ps.tick;
          if (cnt != '0) begin
            cnt_n = cnt - WIDTH'(1);
          end else if (GAP > 0) begin
            state_n = LOW_GAP;
            gcnt_n  = GAP_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      LOW_GAP: begin
        drop_n = ps.tick;
        if (gcnt != '0) gcnt_n = gcnt - GW'(1);
        else            state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        gcnt_n  = '0;
      end
    endcase
    level_n = (state_n == HIGH);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      level_r <= level_n;
      busy_r  <= busy_n;
      drop_r  <= drop_n;
    end
  end

  assign ps.level = level_r;
  assign ps.busy  = busy_r;
  assign ps.drop  = drop_r;
endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: four parameter variants driven in lockstep and checked
// against a timestamp-based reference model, plus fixed vectors and corner sequences.
module tb_pulse_stretch;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] len = '0;

  always #5 clk = ~clk;

  pulse_stretch_if #(.WIDTH(8)) ifa ();
  pulse_stretch_if #(.WIDTH(8)) ifb ();
  pulse_stretch_if #(.WIDTH(8)) ifc ();
  pulse_stretch_if #(.WIDTH(8)) ifd ();

  assign ifa.tick = tick;  assign ifa.len = len;
  assign ifb.tick = tick;  assign ifb.len = len;
  assign ifc.tick = tick;  assign ifc.len = len;
  assign ifd.tick = tick;  assign ifd.len = len;

  pulse_stretch #(.WIDTH(8), .GAP(2), .RETRIG(1'b0)) dut_a (.clk(clk), .reset(rst), .ps(ifa));
  pulse_stretch #(.WIDTH(8), .GAP(2), .RETRIG(1'b1)) dut_b (.clk(clk), .reset(rst), .ps(ifb));
  pulse_stretch #(.WIDTH(8), .GAP(1), .RETRIG(1'b0)) dut_c (.clk(clk), .reset(rst), .ps(ifc));
  pulse_stretch #(.WIDTH(8), .GAP(0), .RETRIG(1'b0)) dut_d (.clk(clk), .reset(rst), .ps(ifd));

  logic [3:0] lv, bz, dr;
  assign lv = {ifd.level, ifc.level, ifb.level, ifa.level};
  assign bz = {ifd.busy,  ifc.busy,  ifb.busy,  ifa.busy};
  assign dr = {ifd.drop,  ifc.drop,  ifb.drop,  ifa.drop};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: for each variant, the last edge after which level is high (he)
  // and the last edge after which busy is high (be); state is derived by comparing times.
  int gapv[4] = '{2, 2, 1, 0};
  bit rtg[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  int he[4]   = '{-100, -100, -100, -100};
  int be[4]   = '{-100, -100, -100, -100};
  bit md[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
  int edge_n  = 0;

  task automatic check(input string name, input int k, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %b expected %b", name, k, edge_n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic [7:0] l);
    int plen, prev;
    rst = r; tick = t; len = l;
    @(posedge clk);
    #1;
    edge_n++;
    prev = edge_n - 1;
    plen = (l == 8'd0) ? 1 : int'(l);
    for (int k = 0; k < 4; k++) begin
      md[k] = 1'b0;
      if (r) begin
        he[k] = -100;
        be[k] = -100;
      end else if (t) begin
        if (prev > be[k]) begin
          he[k] = edge_n + plen - 1;
          be[k] = he[k] + gapv[k];
        end else if (prev <= he[k] && rtg[k]) begin
          he[k] = edge_n + plen - 1;
          be[k] = he[k] + gapv[k];
        end else begin
          md[k] = 1'b1;
        end
      end
      check("model_level", k, lv[k], edge_n <= he[k]);
      check("model_busy",  k, bz[k], edge_n <= be[k]);
      check("model_drop",  k, dr[k], md[k]);
    end
  endtask

  typedef struct {
    logic       r;
    logic       t;
    logic [7:0] l;
    logic       lvl;
    logic       bsy;
    logic       drp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic t, input logic [7:0] l,
                     input logic lvl, input logic bsy, input logic drp);
    vec_t v;
    v.r = r; v.t = t; v.l = l; v.lvl = lvl; v.bsy = bsy; v.drp = drp;
    vecs.push_back(v);
  endtask

  initial begin
    int highs, rises;
    bit prev_l;

    // Fixed vectors for variant A (GAP=2, no retrigger); outputs observed after each edge
    add(1, 0, 0,  0, 0, 0);
    add(0, 1, 3,  1, 1, 0);   // len=3 pulse
    add(0, 0, 0,  1, 1, 0);
    add(0, 0, 0,  1, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 0, 0);
    add(0, 1, 4,  1, 1, 0);   // len=4, second tick dropped
    add(0, 0, 0,  1, 1, 0);
    add(0, 1, 4,  1, 1, 1);
    add(0, 0, 0,  1, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 0, 0);
    add(0, 1, 0,  1, 1, 0);   // len=0 acts as 1, tick in gap dropped
    add(0, 0, 0,  0, 1, 0);
    add(0, 1, 5,  0, 1, 1);
    add(0, 0, 0,  0, 0, 0);
    add(0, 1, 8,  1, 1, 0);   // reset during 3rd high cycle
    add(0, 0, 0,  1, 1, 0);
    add(1, 0, 0,  0, 0, 0);
    add(0, 0, 0,  0, 0, 0);
    add(1, 1, 5,  0, 0, 0);   // reset beats tick
    add(0, 1, 8,  1, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 1, 0);
    add(0, 0, 0,  0, 0, 0);
    add(0, 1, 255, 1, 1, 0);  // maximum length boundary start

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].l);
      check("vec_level", 0, ifa.level, vecs[i].lvl);
      check("vec_busy",  0, ifa.busy,  vecs[i].bsy);
      check("vec_drop",  0, ifa.drop,  vecs[i].drp);
    end
    for (int i = 0; i < 254; i++) step(0, 0, 0);
    check("max_len_last", 0, ifa.level, 1'b1);
    step(0, 0, 0);
    check("max_len_end", 0, ifa.level, 1'b0);

    // Retrigger on variant B: 2 + 4 contiguous high cycles, no drop
    step(1, 0, 0);
    highs = 0; rises = 0; prev_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 2) step(0, 1, 4);
      else                  step(0, 0, 0);
      if (ifb.level) highs++;
      if (ifb.level && !prev_l) rises++;
      prev_l = ifb.level;
      check("retrig_drop", 1, ifb.drop, 1'b0);
    end
    n_tests++;
    if (highs != 6 || rises != 1) begin
      n_fail++;
      $display("FAIL retrig_len dut1: got %0d high cycles in %0d pulses, expected 6 in 1", highs, rises);
    end

    // Held tick on variant C (GAP=1): level 1,1,0,0 repeating, drop except on accept edges
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 2);
      check("held_level", 2, ifc.level, (i % 4) < 2);
      check("held_drop",  2, ifc.drop,  (i % 4) != 0);
    end
    step(0, 0, 0);

    // Randomized traffic, all variants against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, t;
      logic [7:0] l;
      r = ($urandom_range(0, 59) == 0);
      t = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      step(r, t, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
